// File: rtl/gf2n_power_sbox_iter_if.sv
// Valid/ready bundle for the iterative GF(2^N) power-map S-box.
// The master drives x/in_valid/out_ready; the slave returns y and status.
interface gf2n_power_sbox_iter_if #(
  parameter int N = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         busy;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/gf2n_power_sbox_iter.sv
// Iterative power-map S-box y = x^EXP ^ {N{^(x & MASK)}} over GF(2^N).
// Left-to-right square-and-multiply, one exponent bit per clock.
module gf2n_power_sbox_iter #(
  parameter int          N    = 6,
  parameter logic [N:0]  POLY = 7'b1000011,
  parameter int unsigned EXP  = 52,
  parameter logic [N-1:0] MASK = 6'b010100
) (
  input logic clk,
  input logic rst,
  gf2n_power_sbox_iter_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] EXP_BITS = EXP[N-1:0];

  if (POLY[N] != 1'b1) begin : g_poly_chk
    $fatal(1, "POLY must have bit N set");
  end
  if (EXP >= 2**N) begin : g_exp_chk
    $fatal(1, "EXP must be below 2^N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [N-1:0]   x_reg, acc, y_reg;
  logic [CW-1:0]  cnt;
  logic           par;
  logic [N-1:0]   sq, sq_x, acc_next;

  // Carry-less product followed by reduction from the top bit down.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] p;
    p = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) p = p ^ ({{(N-1){1'b0}}, a} << i);
    for (int i = 2*N-2; i >= N; i--)
      if (p[i]) p = p ^ ({{(N-2){1'b0}}, POLY} << (i - N));
    return p[N-1:0];
  endfunction

  always_comb begin
    sq       = gf_mul(acc, acc);
    sq_x     = gf_mul(sq, x_reg);
    acc_next = EXP_BITS[cnt] ? sq_x : sq;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.in_valid)     state_n = RUN;
      RUN:  if (cnt == '0)        state_n = DONE;
      DONE: if (bus.out_ready)    state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      y_reg <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          x_reg <= bus.x;
          acc   <= {{(N-1){1'b0}}, 1'b1};
          cnt   <= CW'(N-1);
          par   <= ^(bus.x & MASK);
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) y_reg <= acc_next ^ {N{par}};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.y         = y_reg;

endmodule

// File: tb/tb_gf2n_power_sbox_iter.sv
// Bench for the power-map S-box: three builds (EXP=52, 3, 62) run in lockstep
// against a repeated-multiplication reference model.
module tb_gf2n_power_sbox_iter;
  localparam int N = 6;
  localparam logic [N:0]   POLY = 7'b1000011;
  localparam logic [N-1:0] MASK = 6'b010100;
  localparam int NE = 3;

  logic clk = 1'b0;
  logic rst;
  logic iv;
  logic [N-1:0] xv;
  logic ordy;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf2n_power_sbox_iter_if #(.N(N)) b0 ();
  gf2n_power_sbox_iter_if #(.N(N)) b1 ();
  gf2n_power_sbox_iter_if #(.N(N)) b2 ();

  assign b0.in_valid = iv;  assign b0.x = xv;  assign b0.out_ready = ordy;
  assign b1.in_valid = iv;  assign b1.x = xv;  assign b1.out_ready = ordy;
  assign b2.in_valid = iv;  assign b2.x = xv;  assign b2.out_ready = ordy;

  logic [N-1:0] ys [NE];
  logic         ovs[NE];
  assign ys[0] = b0.y;  assign ovs[0] = b0.out_valid;
  assign ys[1] = b1.y;  assign ovs[1] = b1.out_valid;
  assign ys[2] = b2.y;  assign ovs[2] = b2.out_valid;

  gf2n_power_sbox_iter #(.N(N), .POLY(POLY), .EXP(52), .MASK(MASK)) d0 (.clk(clk), .rst(rst), .bus(b0));
  gf2n_power_sbox_iter #(.N(N), .POLY(POLY), .EXP(3),  .MASK(MASK)) d1 (.clk(clk), .rst(rst), .bus(b1));
  gf2n_power_sbox_iter #(.N(N), .POLY(POLY), .EXP(62), .MASK(MASK)) d2 (.clk(clk), .rst(rst), .bus(b2));

  function automatic int exp_of(int i);
    case (i)
      0: return 52;
      1: return 3;
      default: return 62;
    endcase
  endfunction

  // Shift-and-add multiply, reducing after every shift.
  function automatic logic [N-1:0] ref_mul(logic [N-1:0] a, logic [N-1:0] b);
    logic [N:0]   aa = {1'b0, a};
    logic [N-1:0] r  = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) r = r ^ aa[N-1:0];
      aa = aa << 1;
      if (aa[N]) aa = aa ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] ref_par(logic [N-1:0] x);
    return {N{^(x & MASK)}};
  endfunction

  function automatic logic [N-1:0] ref_sbox(logic [N-1:0] x, int e);
    logic [N-1:0] p = 1;
    for (int i = 0; i < e; i++) p = ref_mul(p, x);
    return p ^ ref_par(x);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_one(input logic [N-1:0] xin, input int pre, input int post);
    int lat;
    iv = 1'b0; ordy = 1'b0;
    repeat (pre) @(negedge clk);
    iv = 1'b1; xv = xin;
    @(negedge clk);
    chk("accept_in_ready", 32'(b0.in_ready), 0);
    chk("accept_busy", 32'(b0.busy), 1);
    lat = 0;
    // Garbage on in_valid/x while busy must be ignored.
    while (!ovs[0] && lat < 4*N) begin
      iv = 1'($urandom_range(0, 1)); xv = N'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    for (int i = 0; i < NE; i++) begin
      chk("out_valid_lockstep", 32'(ovs[i]), 1);
      chk("y", 32'(ys[i]), 32'(ref_sbox(xin, exp_of(i))));
    end
    repeat (post) begin
      iv = 1'($urandom_range(0, 1)); xv = N'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(ovs[0]), 1);
      chk("hold_in_ready", 32'(b0.in_ready), 0);
      chk("hold_y", 32'(ys[0]), 32'(ref_sbox(xin, 52)));
    end
    iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("drain_out_valid", 32'(ovs[0]), 0);
    chk("drain_in_ready", 32'(b0.in_ready), 1);
    chk("drain_busy", 32'(b0.busy), 0);
    chk("idle_y_kept", 32'(ys[0]), 32'(ref_sbox(xin, 52)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [N-1:0] xs;
    rst = 1'b1; iv = 1'b0; xv = '0; ordy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(b0.in_ready), 1);
    chk("rst_out_valid", 32'(ovs[0]), 0);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_y", 32'(ys[0]), 0);

    run_one(6'b000000, 1, 0);
    chk("x0_exp52", 32'(ys[0]), 32'(6'b000000));
    run_one(6'b000001, 0, 1);
    chk("x1_exp52", 32'(ys[0]), 32'(6'b000001));
    run_one(6'b000100, 2, 0);
    chk("x4_exp52", 32'(ys[0]), 32'(6'b100010));
    chk("x4_exp3", 32'(ys[1]), 32'(6'b111100));
    run_one(6'b000010, 0, 0);
    chk("x2_exp3", 32'(ys[1]), 32'(6'b001000));

    run_one(6'h2d, 0, 20);

    // Reset in the middle of RUN abandons the operation.
    iv = 1'b1; xv = 6'h17;
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(ovs[0]), 0);
    chk("midrst_in_ready", 32'(b0.in_ready), 1);
    chk("midrst_busy", 32'(b0.busy), 0);
    chk("midrst_y", 32'(ys[0]), 0);
    seen = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (ovs[0]) seen++;
    end
    chk("midrst_no_pulse", 32'(seen), 0);

    for (int v = 0; v < (1 << N); v++) begin
      xs = N'(v);
      run_one(xs, $urandom_range(0, 3), $urandom_range(0, 3));
      if (xs != '0)
        chk("inverse", 32'(ref_mul(xs, ys[2] ^ ref_par(xs))), 1);
      else
        chk("inverse_zero", 32'(ys[2]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
